reg_file: RTL and testbench



---
 rtl/reg_file_if.sv | 26 ++
 rtl/reg_file.sv | 72 +++++++
 tb/tb_reg_file.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// Register-file access bundle: two combinational read ports, one write port,
// and the committed-write counter. The datapath drives as master; the
// register file receives as slave.
interface reg_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [15:0]       wr_count;

  modport master (
    output ra1, ra2, we, wa, wd,
    input  rd1, rd2, wr_count
  );

  modport slave (
    input  ra1, ra2, we, wa, wd,
    output rd1, rd2, wr_count
  );
endinterface

// File: rtl/reg_file.sv
// MIPS general-purpose register file: 2**ADDR_W words, register 0 reads as
// zero, two combinational read ports with optional write-first bypass, one
// synchronous write port and a saturating committed-write counter.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input logic       clk,
  input logic       reset,
  reg_file_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [15:0]       r_wr_count;
  logic              w_commit;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  // A write only commits to a non-zero destination; we gates it so X on wa/wd
  // with we=0 cannot reach storage.
  assign w_commit = bus.we && (bus.wa != '0);

  // Storage: reset clears every word, otherwise demultiplex wd into reg[wa].
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i[ADDR_W-1:0]] <= '0;
      end
    end else if (w_commit) begin
      r_mem[bus.wa] <= bus.wd;
    end
  end

  // Committed-write counter, saturates at all-ones; reset wins over a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_count <= '0;
    end else if (w_commit && (r_wr_count != '1)) begin
      r_wr_count <= r_wr_count + 16'd1;
    end
  end

  // Read port 1: zero register, then bypass of the in-flight write, then storage.
  always_comb begin
    w_rd1 = '0;
    if (bus.ra1 != '0) begin
      if (BYPASS && bus.we && (bus.wa == bus.ra1)) begin
        w_rd1 = bus.wd;
      end else begin
        w_rd1 = r_mem[bus.ra1];
      end
    end
  end

  // Read port 2: same selection as port 1, fully independent.
  always_comb begin
    w_rd2 = '0;
    if (bus.ra2 != '0) begin
      if (BYPASS && bus.we && (bus.wa == bus.ra2)) begin
        w_rd2 = bus.wd;
      end else begin
        w_rd2 = r_mem[bus.ra2];
      end
    end
  end

  assign bus.rd1      = w_rd1;
  assign bus.rd2      = w_rd2;
  assign bus.wr_count = r_wr_count;
endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: one instance with bypass, one without, driven with the
// same stimulus. Expected values are queued when stimulus is applied and
// popped against the DUT outputs away from the clock edge.
module tb_reg_file;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();
  reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus_n ();

  assign bus_n.ra1 = bus_b.ra1;
  assign bus_n.ra2 = bus_b.ra2;
  assign bus_n.we  = bus_b.we;
  assign bus_n.wa  = bus_b.wa;
  assign bus_n.wd  = bus_b.wd;

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );
  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_n (
    .clk(clk), .reset(reset), .bus(bus_n)
  );

  int checks   = 0;
  int failures = 0;

  // sel: 0 rd1 bypass, 1 rd2 bypass, 2 rd1 plain, 3 rd2 plain,
  //      4 wr_count bypass, 5 wr_count plain
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  // Reference model of the architectural state
  logic [31:0] m_mem [32];
  int unsigned m_cnt;

  function automatic logic [31:0] observed(int sel);
    case (sel)
      0:       return bus_b.rd1;
      1:       return bus_b.rd2;
      2:       return bus_n.rd1;
      3:       return bus_n.rd2;
      4:       return {16'h0, bus_b.wr_count};
      default: return {16'h0, bus_n.wr_count};
    endcase
  endfunction

  function automatic logic [31:0] exp_rd(logic [4:0] ra, bit byp);
    if (ra == 5'd0) return 32'h0;
    if (byp && bus_b.we === 1'b1 && bus_b.wa == ra) return bus_b.wd;
    return m_mem[ra];
  endfunction

  task automatic push(string n, int sel, logic [31:0] v);
    exp_t x;
    x.name = n; x.sel = sel; x.val = v;
    sb.push_back(x);
  endtask

  // Advance one rising edge, update the model with what the DUT sampled
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
      m_cnt = 0;
    end else if (bus_b.we === 1'b1 && bus_b.wa != 5'd0) begin
      m_mem[bus_b.wa] = bus_b.wd;
      if (m_cnt < 32'd65535) m_cnt++;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_b.we = 1'b0; bus_b.wa = '0; bus_b.wd = '0;
    bus_b.ra1 = '0; bus_b.ra2 = '0;
    tick(); tick();
    reset = 1'b0;
    bus_b.wa = 'x; bus_b.wd = 'x;
    for (int a = 0; a < 32; a++) begin
      bus_b.ra1 = 5'(a); bus_b.ra2 = 5'(a);
      push("reset_rd1_byp", 0, 32'h0);
      push("reset_rd2_byp", 1, 32'h0);
      push("reset_rd1_nob", 2, 32'h0);
      push("reset_rd2_nob", 3, 32'h0);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (observed(e.sel) !== e.val) begin
          failures++;
          $display("FAIL %s addr=%0d: got %h expected %h", e.name, a, observed(e.sel), e.val);
        end
      end
    end
    tick();
    bus_b.ra1 = 5'd8; bus_b.ra2 = 5'd31;
    push("xidle_rd1_byp", 0, 32'h0);
    push("xidle_rd2_nob", 3, 32'h0);
    push("reset_cnt_byp", 4, 32'h0);
    push("reset_cnt_nob", 5, 32'h0);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (observed(e.sel) !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, observed(e.sel), e.val);
      end
    end
  endtask

  task automatic test_write_read();
    bus_b.we = 1'b1; bus_b.wa = 5'd8; bus_b.wd = 32'hDEADBEEF;
    tick();
    bus_b.we = 1'b0;
    bus_b.ra1 = 5'd8; bus_b.ra2 = 5'd8;
    push("wr_rd1_byp", 0, 32'hDEADBEEF);
    push("wr_rd2_byp", 1, 32'hDEADBEEF);
    push("wr_rd1_nob", 2, 32'hDEADBEEF);
    push("wr_rd2_nob", 3, 32'hDEADBEEF);
    push("wr_cnt_byp", 4, 32'd1);
    push("wr_cnt_nob", 5, 32'd1);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (observed(e.sel) !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, observed(e.sel), e.val);
      end
    end
  endtask

  task automatic test_zero_write();
    bus_b.we = 1'b1; bus_b.wa = 5'd0; bus_b.wd = 32'hFFFFFFFF;
    bus_b.ra1 = 5'd0;
    push("r0_bypass_rd1", 0, 32'h0);
    push("r0_plain_rd1", 2, 32'h0);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (observed(e.sel) !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, observed(e.sel), e.val);
      end
    end
    tick();
    bus_b.we = 1'b0;
    push("r0_after_rd1_byp", 0, 32'h0);
    push("r0_after_rd1_nob", 2, 32'h0);
    push("r0_cnt_byp", 4, 32'd1);
    push("r0_cnt_nob", 5, 32'd1);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (observed(e.sel) !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, observed(e.sel), e.val);
      end
    end
  endtask

  task automatic test_bypass();
    bus_b.we = 1'b1; bus_b.wa = 5'd5; bus_b.wd = 32'h00000001;
    tick();
    bus_b.wd = 32'h12345678; bus_b.ra2 = 5'd5; bus_b.ra1 = 5'd8;
    push("byp_pre_rd2_byp", 1, 32'h12345678);
    push("byp_pre_rd2_nob", 3, 32'h00000001);
    push("byp_other_rd1", 0, 32'hDEADBEEF);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (observed(e.sel) !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, observed(e.sel), e.val);
      end
    end
    tick();
    bus_b.we = 1'b0;
    push("byp_post_rd2_byp", 1, 32'h12345678);
    push("byp_post_rd2_nob", 3, 32'h12345678);
    push("byp_cnt_byp", 4, 32'd3);
    push("byp_cnt_nob", 5, 32'd3);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (observed(e.sel) !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, observed(e.sel), e.val);
      end
    end
  endtask

  task automatic test_reset_priority();
    reset = 1'b1;
    bus_b.we = 1'b1; bus_b.wa = 5'd3; bus_b.wd = 32'hAAAA5555;
    tick();
    reset = 1'b0; bus_b.we = 1'b0;
    bus_b.ra1 = 5'd3; bus_b.ra2 = 5'd8;
    push("rstp_r3_nob", 2, 32'h0);
    push("rstp_r8_lost", 3, 32'h0);
    push("rstp_cnt_byp", 4, 32'd0);
    push("rstp_cnt_nob", 5, 32'd0);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (observed(e.sel) !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, observed(e.sel), e.val);
      end
    end
    bus_b.we = 1'b1;
    tick();
    bus_b.we = 1'b0;
    push("rstp_r3_wr_byp", 0, 32'hAAAA5555);
    push("rstp_r3_wr_nob", 2, 32'hAAAA5555);
    push("rstp_cnt1_byp", 4, 32'd1);
    push("rstp_cnt1_nob", 5, 32'd1);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (observed(e.sel) !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, observed(e.sel), e.val);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 300; n++) begin
      bus_b.we  = ($urandom_range(0, 3) != 0);
      bus_b.wa  = 5'($urandom_range(0, 31));
      bus_b.wd  = $urandom();
      bus_b.ra1 = ($urandom_range(0, 2) == 0) ? bus_b.wa : 5'($urandom_range(0, 31));
      bus_b.ra2 = ($urandom_range(0, 3) == 0) ? bus_b.ra1 : 5'($urandom_range(0, 31));
      push("b2b_rd1_byp", 0, exp_rd(bus_b.ra1, 1'b1));
      push("b2b_rd2_byp", 1, exp_rd(bus_b.ra2, 1'b1));
      push("b2b_rd1_nob", 2, exp_rd(bus_b.ra1, 1'b0));
      push("b2b_rd2_nob", 3, exp_rd(bus_b.ra2, 1'b0));
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (observed(e.sel) !== e.val) begin
          failures++;
          $display("FAIL %s cycle=%0d: got %h expected %h", e.name, n, observed(e.sel), e.val);
        end
      end
      tick();
      push("b2b_cnt_byp", 4, m_cnt);
      push("b2b_cnt_nob", 5, m_cnt);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (observed(e.sel) !== e.val) begin
          failures++;
          $display("FAIL %s cycle=%0d: got %h expected %h", e.name, n, observed(e.sel), e.val);
        end
      end
    end
    bus_b.we = 1'b0;
  endtask

  task automatic test_saturation();
    reset = 1'b1; bus_b.we = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 65540; i++) begin
      bus_b.we = 1'b1;
      bus_b.wa = 5'((i % 31) + 1);
      bus_b.wd = 32'(i) ^ 32'h5A5A0000;
      tick();
      if (i == 65533) begin
        push("sat_cnt_fffe_byp", 4, 32'h0000FFFE);
        push("sat_cnt_fffe_nob", 5, 32'h0000FFFE);
        while (sb.size() > 0) begin
          e = sb.pop_front();
          checks++;
          if (observed(e.sel) !== e.val) begin
            failures++;
            $display("FAIL %s: got %h expected %h", e.name, observed(e.sel), e.val);
          end
        end
      end
    end
    bus_b.we = 1'b0; bus_b.wa = 'x; bus_b.wd = 'x;
    push("sat_cnt_byp", 4, 32'h0000FFFF);
    push("sat_cnt_nob", 5, 32'h0000FFFF);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (observed(e.sel) !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, observed(e.sel), e.val);
      end
    end
    for (int r = 1; r < 32; r++) begin
      int last;
      // highest i < 65540 with (i % 31) + 1 == r
      last = ((65539 - (r - 1)) / 31) * 31 + (r - 1);
      bus_b.ra1 = 5'(r); bus_b.ra2 = 5'(32 - r);
      push("sat_last_rd1_byp", 0, 32'(last) ^ 32'h5A5A0000);
      push("sat_last_rd1_nob", 2, 32'(last) ^ 32'h5A5A0000);
      push("sat_last_rd2_nob", 3, m_mem[32 - r]);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (observed(e.sel) !== e.val) begin
          failures++;
          $display("FAIL %s r=%0d: got %h expected %h", e.name, r, observed(e.sel), e.val);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    m_cnt = 0;
    test_reset();
    test_write_read();
    test_zero_write();
    test_bypass();
    test_reset_priority();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
